// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: lsu_op field layout,
// funct3 encodings and controller state type.
package lsu_pkg;

   localparam int unsigned LSU_EN = 3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Undefined funct3 codes behave as W for steering but never flag misalignment.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
             ((f3 == F3_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
interface mem_lsu_ctrl_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ack, rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_st_funct3,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_st_wdata,
   output logic [3:0]  o_st_be,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_st_wdata = i_st_data;
      o_st_be    = 4'hF;
      case (i_st_funct3)
         F3_B, F3_BU: begin
            o_st_wdata = {4{i_st_data[7:0]}};
            o_st_be    = 4'b0001 << i_st_off;
         end
         F3_H, F3_HU: begin
            o_st_wdata = {2{i_st_data[15:0]}};
            o_st_be    = 4'b0011 << i_st_off;
         end
         default: ;
      endcase
   end

   assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
   assign w_byte    = w_shifted[7:0];
   assign w_half    = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

   always_comb begin
      o_ld_data = i_ld_rdata;
      case (i_ld_funct3)
         F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ld_data = {24'h000000, w_byte};
         F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ld_data = {16'h0000, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: issues one data-memory transaction per access,
// stalls the pipeline until it completes, and times out on a missing ack.
module mem_lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  inst_vld_mem,
   input  logic                  mem_wren_mem,
   input  logic [3:0]            lsu_op_mem,
   input  logic [31:0]           alu_data_mem,
   input  logic [31:0]           rs2_data_mem,
   mem_lsu_ctrl_if.master        dmem,
   output logic                  o_stall,
   output logic [31:0]           o_ld_data,
   output logic                  o_lsu_done,
   output logic                  o_misalign,
   output logic                  o_bus_err
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   lsu_state_t  r_state;
   logic [TW-1:0] r_timer;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_ld_data;
   logic        r_done;
   logic        r_misalign;
   logic        r_bus_err;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        w_start;
   logic        w_misalign;
   logic [31:0] w_st_wdata;
   logic [3:0]  w_st_be;
   logic [31:0] w_ld_ext;

   assign w_start    = inst_vld_mem & lsu_op_mem[LSU_EN];
   assign w_misalign = is_misaligned(lsu_op_mem[2:0], alu_data_mem[1:0]);

   // Load extraction uses the funct3/offset captured at issue, not the live MEM inputs.
   lsu_lane_align u_lane_align (
      .i_st_funct3 (lsu_op_mem[2:0]),
      .i_st_off    (alu_data_mem[1:0]),
      .i_st_data   (rs2_data_mem),
      .o_st_wdata  (w_st_wdata),
      .o_st_be     (w_st_be),
      .i_ld_funct3 (r_funct3),
      .i_ld_off    (r_off),
      .i_ld_rdata  (dmem.rdata),
      .o_ld_data   (w_ld_ext)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_ld_data  <= '0;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         r_funct3   <= '0;
         r_off      <= '0;
      end else begin
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  if (w_misalign) begin
                     r_misalign <= 1'b1;
                  end else begin
                     r_req    <= 1'b1;
                     r_we     <= mem_wren_mem;
                     r_addr   <= {alu_data_mem[31:2], 2'b00};
                     r_wdata  <= w_st_wdata;
                     r_be     <= w_st_be;
                     r_funct3 <= lsu_op_mem[2:0];
                     r_off    <= alu_data_mem[1:0];
                     r_timer  <= '0;
                     r_state  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (dmem.ack) begin
                  r_req  <= 1'b0;
                  r_done <= 1'b1;
                  if (!r_we) begin
                     r_ld_data <= w_ld_ext;
                  end
                  r_state <= DONE;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  r_req     <= 1'b0;
                  r_ld_data <= '0;
                  r_bus_err <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            // The completed instruction is still in MEM during DONE, so start is ignored.
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_stall = ((r_state == IDLE) && w_start && !w_misalign) || (r_state == BUSY);

   assign dmem.req   = r_req;
   assign dmem.we    = r_we;
   assign dmem.addr  = r_addr;
   assign dmem.wdata = r_wdata;
   assign dmem.be    = r_be;

   assign o_ld_data  = r_ld_data;
   assign o_lsu_done = r_done;
   assign o_misalign = r_misalign;
   assign o_bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed plus randomized bench for mem_lsu_ctrl against a byte-arithmetic reference model.
module tb_mem_lsu_ctrl;
   import lsu_pkg::*;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_vld = 1'b0;
   logic        wren = 1'b0;
   logic [3:0]  lsu_op = 4'h0;
   logic [31:0] alu = 32'h0;
   logic [31:0] rs2 = 32'h0;
   logic        stall;
   logic [31:0] ld_data;
   logic        done;
   logic        misal;
   logic        berr;

   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] m_ld = 32'h0;

   mem_lsu_ctrl_if u_if ();

   mem_lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .inst_vld_mem (inst_vld),
      .mem_wren_mem (wren),
      .lsu_op_mem   (lsu_op),
      .alu_data_mem (alu),
      .rs2_data_mem (rs2),
      .dmem         (u_if),
      .o_stall      (stall),
      .o_ld_data    (ld_data),
      .o_lsu_done   (done),
      .o_misalign   (misal),
      .o_bus_err    (berr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Access width in bytes; every code other than B/BU/H/HU behaves as a word.
   function automatic int unsigned m_size(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
      return (m_size(f3) == 2 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
      int unsigned sz;
      sz = m_size(f3);
      if (sz == 4) return 4'hF;
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      int unsigned sz;
      sz = m_size(f3);
      if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
      if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rd);
      int unsigned sz;
      int unsigned lane;
      logic [31:0] mask;
      logic [31:0] v;
      sz = m_size(f3);
      if (sz == 4) return rd;
      lane = (sz == 2) ? (int'(off) & 2) : int'(off);
      mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v = (rd >> (8 * lane)) & mask;
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   // Called just after a posedge with the controller idle; ack_after==0 means never ack.
   task automatic run_access(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int ack_after);
      int stall_cyc;
      int busy;
      bit timed_out;
      timed_out = (ack_after == 0);
      inst_vld = 1'b1;
      wren = we;
      lsu_op = {1'b1, f3};
      alu = a;
      rs2 = d;
      u_if.ack = 1'b0;
      #1;
      check({nm, "_stall_issue"}, 32'(stall), 32'd1);
      stall_cyc = 1;
      @(posedge clk); #1;
      check({nm, "_req"}, 32'(u_if.req), 32'd1);
      check({nm, "_addr"}, u_if.addr, {a[31:2], 2'b00});
      check({nm, "_we"}, 32'(u_if.we), 32'(we));
      if (we) begin
         check({nm, "_be"}, 32'(u_if.be), 32'(m_be(f3, a[1:0])));
         check({nm, "_wdata"}, u_if.wdata, m_wdata(f3, d));
      end
      busy = 1;
      while (stall === 1'b1 && busy <= 3 * TIMEOUT) begin
         check({nm, "_req_held"}, 32'(u_if.req), 32'd1);
         stall_cyc++;
         if (busy == ack_after) begin
            u_if.ack = 1'b1;
            u_if.rdata = rd;
         end
         @(posedge clk); #1;
         u_if.ack = 1'b0;
         u_if.rdata = $urandom;
         busy++;
      end
      if (timed_out) m_ld = 32'h0;
      else if (!we) m_ld = m_load(f3, a[1:0], rd);
      check({nm, "_stall_cycles"}, 32'(stall_cyc),
            32'(1 + (timed_out ? int'(TIMEOUT) : ack_after)));
      check({nm, "_done"}, 32'(done), 32'd1);
      check({nm, "_bus_err"}, 32'(berr), 32'(timed_out));
      check({nm, "_req_drop"}, 32'(u_if.req), 32'd0);
      check({nm, "_ld_data"}, ld_data, m_ld);
      @(posedge clk); #1;
      check({nm, "_done_clr"}, 32'(done), 32'd0);
      check({nm, "_no_reissue"}, 32'(u_if.req), 32'd0);
      inst_vld = 1'b0;
      lsu_op = 4'h0;
   endtask

   task automatic run_misalign(input string nm, input logic we, input logic [2:0] f3,
                               input logic [31:0] a);
      inst_vld = 1'b1;
      wren = we;
      lsu_op = {1'b1, f3};
      alu = a;
      rs2 = $urandom;
      #1;
      check({nm, "_mis_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      check({nm, "_mis_pulse"}, 32'(misal), 32'd1);
      check({nm, "_mis_noreq"}, 32'(u_if.req), 32'd0);
      check({nm, "_mis_nodone"}, 32'(done), 32'd0);
      inst_vld = 1'b0;
      lsu_op = 4'h0;
      @(posedge clk); #1;
      check({nm, "_mis_clr"}, 32'(misal), 32'd0);
      check({nm, "_mis_noreq2"}, 32'(u_if.req), 32'd0);
   endtask

   initial begin
      u_if.ack = 1'b0;
      u_if.rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(u_if.req), 32'd0);
      check("rst_we", 32'(u_if.we), 32'd0);
      check("rst_addr", u_if.addr, 32'd0);
      check("rst_wdata", u_if.wdata, 32'd0);
      check("rst_be", 32'(u_if.be), 32'd0);
      check("rst_ld", ld_data, 32'd0);
      check("rst_flags", {29'd0, done, misal, berr}, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_access("sw", 1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 1);
      run_access("lb", 1'b0, F3_B, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1);
      check("lb_value", ld_data, 32'hFFFF_FF80);
      run_access("lbu", 1'b0, F3_BU, 32'h0000_0203, 32'h0, 32'h80FF_0000, 2);
      check("lbu_value", ld_data, 32'h0000_0080);
      run_misalign("lh", 1'b0, F3_H, 32'h0000_0101);
      run_access("sh", 1'b1, F3_H, 32'h0000_0002, 32'h0000_1234, 32'h0, 5);
      run_access("lhu", 1'b0, F3_HU, 32'h0000_0042, 32'h0, 32'h9ABC_5678, 3);
      check("lhu_value", ld_data, 32'h0000_9ABC);
      run_access("lh_hi", 1'b0, F3_H, 32'h0000_0042, 32'h0, 32'h9ABC_5678, 1);
      check("lh_value", ld_data, 32'hFFFF_9ABC);
      run_access("ld_tmo", 1'b0, F3_W, 32'h0000_0400, 32'h0, 32'h0, 0);
      check("tmo_ld_zero", ld_data, 32'h0);

      // Leave a non-zero load result so the reset clear is observable.
      run_access("lbu2", 1'b0, F3_BU, 32'h0000_0010, 32'h0, 32'h0000_00A5, 1);
      inst_vld = 1'b1;
      wren = 1'b0;
      lsu_op = {1'b1, F3_W};
      alu = 32'h0000_0300;
      @(posedge clk); #1;
      check("rb_req", 32'(u_if.req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      inst_vld = 1'b0;
      lsu_op = 4'h0;
      @(posedge clk); #1;
      m_ld = 32'h0;
      check("rb_req_drop", 32'(u_if.req), 32'd0);
      check("rb_no_done", 32'(done), 32'd0);
      check("rb_no_err", 32'(berr), 32'd0);
      check("rb_ld_clr", ld_data, m_ld);
      check("rb_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      u_if.ack = 1'b1;
      u_if.rdata = 32'h1234_5678;
      @(posedge clk); #1;
      u_if.ack = 1'b0;
      check("rb_late_ack_done", 32'(done), 32'd0);
      check("rb_late_ack_req", 32'(u_if.req), 32'd0);
      check("rb_late_ack_ld", ld_data, m_ld);

      for (int i = 0; i < 24; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         int          ack_after;
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         if (f3 == 3'b011 || f3[2:1] == 2'b11) a[1:0] = 2'b00;
         ack_after = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
         if (m_misaligned(f3, a)) begin
            run_misalign("rnd", 1'($urandom_range(0, 1)), f3, a);
         end else begin
            run_access("rnd", 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, ack_after);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
